// File: rtl/cnt_dispatch_pkg.sv
// Shared types and defaults for the count-request dispatcher slice.
package cnt_dispatch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } disp_state_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/cnt_dispatcher_if.sv
// Producer-side request bus for cnt_dispatcher.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
// the producer holds req_valid and req_cnt stable until that edge.
interface cnt_dispatcher_if
  import cnt_dispatch_pkg::*;
#(
  parameter int W = CNT_W
) ();

  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_cnt;

  modport master (output req_valid, output req_cnt, input req_ready);
  modport slave  (input req_valid, input req_cnt, output req_ready);

endinterface

// File: rtl/cnt_req_fifo.sv
// Show-ahead synchronous FIFO holding queued count requests.
module cnt_req_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     head,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [ADDR_W:0] wptr;
  logic [ADDR_W:0] rptr;

  // Extra pointer bit separates the full and empty cases when the addresses match.
  assign full  = (wptr[ADDR_W] != rptr[ADDR_W]) &&
                 (wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0]);
  assign empty = (wptr == rptr);
  assign level = LVL_W'(wptr - rptr);
  assign head  = mem[rptr[ADDR_W-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wptr[ADDR_W-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full) begin
        wptr <= wptr + 1'b1;
      end
      if (pop && !empty) begin
        rptr <= rptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cnt_dispatcher.sv
// Queues count requests and issues them one at a time to the down-counter.
// Optional statistics outputs (jobs_done, stall_cycles) exist when CNT_DISPATCH_STATS_EN is defined.
module cnt_dispatcher
  import cnt_dispatch_pkg::*;
#(
  parameter int W     = CNT_W,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  cnt_dispatcher_if.slave  req,
  output logic [W-1:0]     cnt_init,
  output logic             start,
  input  logic             ctr_ready,
  output logic             busy,
  output logic             done,
  output logic [LVL_W-1:0] level,
`ifdef CNT_DISPATCH_STATS_EN
  output logic [15:0]      jobs_done,
  output logic [15:0]      stall_cycles,
`endif
  output disp_state_t      state_dbg
);

  disp_state_t  state;
  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [W-1:0] head;

  assign req.req_ready = !full && !rst;
  assign push          = req.req_valid && req.req_ready;
  // Dispatch only from the registered FIFO head, so a fresh push waits one edge.
  assign pop           = (state == IDLE) && !empty && ctr_ready;
  assign state_dbg     = state;

  cnt_req_fifo #(
    .W     (W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (req.req_cnt),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      start    <= 1'b0;
      cnt_init <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      start <= 1'b0;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            start    <= 1'b1;
            cnt_init <= head;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_BUSY;
        end
        // The counter lowers ctr_ready a cycle after it sees start.
        WAIT_BUSY: begin
          if (!ctr_ready) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (ctr_ready) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef CNT_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      jobs_done    <= '0;
      stall_cycles <= '0;
    end else begin
      if ((state == WAIT_DONE) && ctr_ready) begin
        jobs_done <= jobs_done + 16'd1;
      end
      // Work is waiting but the counter is not accepting it.
      if (!empty && (state == IDLE) && !ctr_ready && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cnt_dispatcher.sv
// Directed and randomized bench for cnt_dispatcher with a behavioural counter and queue model.
module tb_cnt_dispatcher;
  import cnt_dispatch_pkg::*;

  localparam int W     = 32;
  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ctr_ready;
  logic [W-1:0]     cnt_init;
  logic             start;
  logic             busy;
  logic             done;
  logic [LVL_W-1:0] level;
  disp_state_t      state_dbg;
`ifdef CNT_DISPATCH_STATS_EN
  logic [15:0]      jobs_done;
  logic [15:0]      stall_cycles;
`endif

  cnt_dispatcher_if #(.W(W)) bus ();

  cnt_dispatcher #(
    .W     (W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.slave),
    .cnt_init     (cnt_init),
    .start        (start),
    .ctr_ready    (ctr_ready),
    .busy         (busy),
    .done         (done),
    .level        (level),
`ifdef CNT_DISPATCH_STATS_EN
    .jobs_done    (jobs_done),
    .stall_cycles (stall_cycles),
`endif
    .state_dbg    (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- counter model ----------------
  // Takes start one edge after it appears, drops ready, stays busy max(cnt,1) edges.
  logic ctr_idle = 1'b1;
  logic hold_low = 1'b0;
  assign ctr_ready = ctr_idle && !hold_low;

  initial begin
    logic         seen;
    logic [W-1:0] val;
    int           rem;
    rem = 0;
    forever begin
      @(negedge clk);
      seen = start;
      val  = cnt_init;
      @(posedge clk);
      #1;
      if (seen) begin
        ctr_idle = 1'b0;
        rem      = (val == '0) ? 1 : int'(val);
      end else if (!ctr_idle) begin
        rem--;
        if (rem == 0) ctr_idle = 1'b1;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         outstanding = 1'b0;
  int           start_count = 0;

  initial begin
    logic         rst_q, push_q, rise_q, rdy_prev, start_prev, have_last, exp_done;
    logic [W-1:0] push_val_q, last_init, exp_v;
    int           cyc, last_cyc;
    rst_q = 1'b1; push_q = 1'b0; rise_q = 1'b0; rdy_prev = 1'b1;
    start_prev = 1'b0; have_last = 1'b0; push_val_q = '0; last_init = '0;
    cyc = 0; last_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_q) begin
        exp_q.delete();
        outstanding = 1'b0;
        last_init   = '0;
        have_last   = 1'b0;
        chk("rst_start", 64'(start), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
      end else begin
        exp_done = rise_q && outstanding;
        chk("done", 64'(done), 64'(exp_done));
        if (exp_done) outstanding = 1'b0;
        if (start) begin
          chk("start_width", 64'(start_prev), 64'(0));
          if (have_last) chk("start_gap_ge4", 64'(cyc - last_cyc >= 4), 64'(1));
          chk("start_has_request", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            chk("dispatch_cnt_init", 64'(cnt_init), 64'(exp_v));
            last_init = exp_v;
          end
          outstanding = 1'b1;
          have_last   = 1'b1;
          last_cyc    = cyc;
          start_count++;
        end
        if (push_q) exp_q.push_back(push_val_q);
      end
      if (!start) chk("cnt_init_hold", 64'(cnt_init), 64'(last_init));
      chk("busy", 64'(busy), 64'(outstanding));
      chk("level", 64'(level), 64'(exp_q.size()));
      if (rst) chk("req_ready_in_rst", 64'(bus.req_ready), 64'(0));
      else     chk("req_ready", 64'(bus.req_ready), 64'(exp_q.size() < DEPTH));
      rst_q      = rst;
      push_q     = bus.req_valid && bus.req_ready;
      push_val_q = bus.req_cnt;
      rise_q     = ctr_ready && !rdy_prev;
      rdy_prev   = ctr_ready;
      start_prev = start;
    end
  end

  // ---------------- driver tasks ----------------
  int max_lvl;
  int stall_seen;

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [W-1:0] v);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cnt   = v;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.req_ready;
      if (!acc) stall_seen++;
      if (int'(level) > max_lvl) max_lvl = int'(level);
      @(posedge clk);
      #1;
      n++;
    end
    bus.req_valid = 1'b0;
    chk("push_accepted", 64'(acc), 64'(1));
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || outstanding || !ctr_idle) && n < 600) begin
      step(1);
      n++;
    end
    chk(tag, 64'(exp_q.size() == 0 && !outstanding && ctr_idle), 64'(1));
    step(2);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int sc, got;
    bus.req_valid = 1'b0;
    bus.req_cnt   = '0;
    max_lvl = 0;
    stall_seen = 0;

    // reset
    step(2);
    @(negedge clk);
    chk("rst_req_ready_low", 64'(bus.req_ready), 64'(0));
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_level", 64'(level), 64'(0));
    chk("reset_start", 64'(start), 64'(0));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_cnt_init", 64'(cnt_init), 64'(0));
    chk("reset_req_ready", 64'(bus.req_ready), 64'(1));
    chk("reset_state", 64'(state_dbg), 64'(IDLE));
    step(1);

    // single job, latency and completion
    push(32'd10);
    @(negedge clk);
    chk("t1_start_not_yet", 64'(start), 64'(0));
    @(negedge clk);
    chk("t1_start", 64'(start), 64'(1));
    chk("t1_cnt_init", 64'(cnt_init), 64'(10));
    @(negedge clk);
    chk("t1_start_pulse_end", 64'(start), 64'(0));
    got = 0;
    for (int i = 0; i < 40 && got == 0; i++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    chk("t1_done_seen", 64'(got), 64'(1));
    @(negedge clk);
    chk("t1_busy_after", 64'(busy), 64'(0));
    step(1);
    drain("t1_drain");

    // back-to-back burst filling the FIFO
    max_lvl = 0;
    stall_seen = 0;
    push(32'd3); push(32'd7); push(32'd1); push(32'd4); push(32'd2);
    push(32'd9);
    chk("t2_level_reached_4", 64'(max_lvl), 64'(4));
    chk("t2_producer_stalled", 64'(stall_seen > 0), 64'(1));
    drain("t2_drain");

    // counter held not-ready with two queued requests
    hold_low = 1'b1;
    push(32'd5); push(32'd6);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_no_start", 64'(start), 64'(0));
      chk("t3_level2", 64'(level), 64'(2));
    end
    step(1);
    hold_low = 1'b0;
    @(negedge clk);
    chk("t3_start_wait_edge", 64'(start), 64'(0));
    @(negedge clk);
    chk("t3_start_after_rise", 64'(start), 64'(1));
    chk("t3_cnt_init", 64'(cnt_init), 64'(5));
    step(1);
    drain("t3_drain");

    // push and pop on the same edge
    hold_low = 1'b1;
    push(32'd11); push(32'd12);
    hold_low = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_cnt   = 32'd13;
    @(negedge clk);
    chk("t5_level_before", 64'(level), 64'(2));
    step(1);
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk("t5_level_same", 64'(level), 64'(2));
    chk("t5_start", 64'(start), 64'(1));
    chk("t5_cnt_init_head", 64'(cnt_init), 64'(11));
    step(1);
    drain("t5_drain");

    // reset while waiting for completion with requests queued
    push(32'd15);
    step(4);
    push(32'd21); push(32'd22); push(32'd23);
    chk("t4_in_wait_done", 64'(state_dbg), 64'(WAIT_DONE));
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t4_level", 64'(level), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_start", 64'(start), 64'(0));
    chk("t4_cnt_init", 64'(cnt_init), 64'(0));
    chk("t4_req_ready", 64'(bus.req_ready), 64'(1));
    sc = start_count;
    repeat (25) @(negedge clk);
    chk("t4_no_restart", 64'(start_count), 64'(sc));
    step(1);
    drain("t4_drain");

    // statistics scenario: 3 jobs, 5 stall cycles
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    hold_low = 1'b1;
    push(32'd4);
    step(5);
    hold_low = 1'b0;
    push(32'd2); push(32'd6);
    drain("stats_drain");
`ifdef CNT_DISPATCH_STATS_EN
    chk("stats_jobs_done", 64'(jobs_done), 64'(3));
    chk("stats_stall_cycles", 64'(stall_cycles), 64'(5));
`endif

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        hold_low = 1'b1;
        step($urandom_range(1, 6));
        hold_low = 1'b0;
      end
      step($urandom_range(0, 2));
      push(W'($urandom_range(0, 12)));
    end
    drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
